// File: rtl/uart_pkg.sv
// Shared types and constants for the UART loopback register block.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Bit period in clocks; integer division, the residual baud error is tolerated.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop input synchronizer plus centre-sampling RX FSM.
// Emits the received byte with a one-cycle valid pulse for good frames only.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1041
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  logic [1:0]           sync_q, sync_d;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 valid_q, valid_d;

  assign rx_s    = sync_q[1];
  assign data_o  = shift_q;
  assign valid_o = valid_q;

  always_comb begin
    sync_d  = {sync_q[0], rx_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    valid_d = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end

      // Half a bit in: a high line here means the falling edge was a glitch.
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Framing error: ignore the line until it returns to idle.
      RX_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/uart_reg.sv
// UART loopback register: latches each good received byte into a single-entry
// register and retransmits it as an 8N1 frame on uart_tx_o.
module uart_reg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 10_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic uart_rx_i,
  output logic uart_tx_o
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned STOP_CLKS    = CLKS_PER_BIT * STOP_BITS;
  localparam int unsigned CNT_W        = $clog2(STOP_CLKS);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  logic [7:0]       rx_data;
  logic             rx_valid;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic [7:0]       data_q, data_d;
  logic             pending_q, pending_d;
  logic             tx_load;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rx_i    (uart_rx_i),
    .data_o  (rx_data),
    .valid_o (rx_valid)
  );

  assign uart_tx_o = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    bit_idx_d  = bit_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;

    case (tx_state_q)
      TX_IDLE: begin
        if (pending_q) begin
          tx_load    = 1'b1;
          tx_shift_d = data_q;
          tx_d       = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end

      TX_START: begin
        if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d   = '0;
          bit_idx_d  = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end

      TX_DATA: begin
        if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d = '0;
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
            bit_idx_d  = bit_idx_q + IDX_W'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end

      TX_STOP: begin
        if (tx_cnt_q == CNT_W'(STOP_CLKS - 1)) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // Single-entry holding register: latest byte wins, a store beats a same-cycle load.
  always_comb begin
    data_d    = data_q;
    pending_d = pending_q;
    if (tx_load) begin
      pending_d = 1'b0;
    end
    if (rx_valid) begin
      data_d    = rx_data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      bit_idx_q  <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      data_q     <= '0;
      pending_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      bit_idx_q  <= bit_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      data_q     <= data_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_uart_reg.sv
// Self-checking bench for uart_reg: drives 8N1 frames, decodes the echo line,
// and compares against a byte-level scoreboard of frames that should be stored.
module tb_uart_reg;

  localparam int unsigned CLK_FREQ = 400_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int          CPB      = CLK_FREQ / BAUD;
  localparam int          HALF     = CPB / 2;

  logic clk_i = 1'b0;
  logic rst_i;
  logic uart_rx_i;
  logic uart_tx_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_fall = 0;
  int fall_cyc = 0;
  int stop_cyc = 0;
  logic rst_seen = 1'b0;
  logic tx_prev = 1'b1;
  logic mon_abort = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_reg #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .uart_rx_i (uart_rx_i),
    .uart_tx_o (uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] got_at(input int i);
    if (i < got_q.size()) return {1'b0, got_q[i]};
    return 9'h1FF;
  endfunction

  // Line must be high on every cycle following a sampled reset.
  initial begin : rst_check
    forever begin
      @(negedge clk_i);
      if (rst_seen) chk("tx_high_in_reset", 32'(uart_tx_o), 32'd1);
    end
  end

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge clk_i);
      if (rst_i) mon_abort = 1'b1;
    end
  endtask

  // Decode frames on uart_tx_o at bit centres.
  initial begin : monitor
    logic [7:0] b;
    logic       sb, pb;
    forever begin
      @(negedge clk_i);
      if (!rst_i && tx_prev && !uart_tx_o) begin
        n_fall++;
        fall_cyc  = cyc;
        mon_abort = 1'b0;
        mon_wait(HALF);
        sb = uart_tx_o;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          b[i] = uart_tx_o;
        end
        mon_wait(CPB);
        pb = uart_tx_o;
        if (!mon_abort) begin
          chk("tx_start_bit", 32'(sb), 32'd0);
          chk("tx_stop_bit", 32'(pb), 32'd1);
          got_q.push_back(b);
        end
      end
      tx_prev = uart_tx_o;
    end
  end

  task automatic drive(input logic v, input int n);
    uart_rx_i = v;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_len);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    stop_cyc = cyc;
    drive(stop_val, stop_len);
  endtask

  task automatic send_good(input logic [7:0] b, input int stop_len);
    exp_q.push_back(b);
    send_byte(b, 1'b1, stop_len);
  endtask

  task automatic check_exact(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(name, 32'(got_at(i)), 32'({1'b0, exp_q[i]}));
    got_q.delete();
    exp_q.delete();
  endtask

  // Echo may skip overwritten bytes but must keep order and end with the newest.
  task automatic check_subseq(input string name);
    int  j;
    logic ok;
    j  = 0;
    ok = 1'b1;
    for (int i = 0; i < got_q.size(); i++) begin
      while (j < exp_q.size() && exp_q[j] != got_q[i]) j++;
      if (j == exp_q.size()) ok = 1'b0;
      else j++;
    end
    chk({name, "_order"}, 32'(ok), 32'd1);
    chk({name, "_last"}, 32'(got_at(got_q.size() - 1)), 32'({1'b0, exp_q[exp_q.size() - 1]}));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    int         n0, lat, kind, k;
    logic [7:0] rb;
    logic [7:0] pat[4];
    pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hFF; pat[3] = 8'h80;

    uart_rx_i = 1'b1;
    rst_i     = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("tx_after_reset", 32'(uart_tx_o), 32'd1);
    repeat (2 * CPB) @(negedge clk_i);
    chk("no_fall_after_reset", 32'(n_fall), 32'd0);

    // Echo sweep
    for (int v = 0; v < 32; v++) begin
      send_good(8'(v), CPB);
      drive(1'b1, 3 * CPB);
    end
    drive(1'b1, 12 * CPB);
    chk("sweep_first", 32'(got_at(0)), 32'h000);
    chk("sweep_last", 32'(got_at(31)), 32'h01F);
    check_exact("sweep");

    // Pattern bytes with latency bound
    for (int p = 0; p < 4; p++) begin
      n0 = n_fall;
      send_good(pat[p], CPB);
      k = 0;
      while (n_fall == n0 && k < 2 * CPB) begin
        @(negedge clk_i);
        k++;
      end
      chk("pattern_echo_started", 32'(n_fall != n0), 32'd1);
      lat = fall_cyc - stop_cyc;
      chk("pattern_latency_in_range", 32'(lat >= HALF && lat <= HALF + 6), 32'd1);
      drive(1'b1, 3 * CPB);
    end
    drive(1'b1, 12 * CPB);
    chk("pattern_first", 32'(got_at(0)), 32'h0A5);
    chk("pattern_last", 32'(got_at(3)), 32'h080);
    check_exact("pattern");

    // Start glitch
    n0 = n_fall;
    drive(1'b0, CPB / 4);
    drive(1'b1, 12 * CPB);
    chk("glitch_no_tx", 32'(n_fall - n0), 32'd0);
    send_good(8'h3C, CPB);
    drive(1'b1, 12 * CPB);
    check_exact("glitch");

    // Framing error
    send_byte(8'h77, 1'b0, CPB);
    drive(1'b1, 3 * CPB);
    send_good(8'h12, CPB);
    drive(1'b1, 12 * CPB);
    chk("framing_next_byte", 32'(got_at(0)), 32'h012);
    check_exact("framing");

    // Back-to-back overrun
    send_good(8'h11, CPB);
    send_good(8'h22, CPB);
    send_good(8'h33, CPB);
    drive(1'b1, 25 * CPB);
    chk("overrun_first", 32'(got_at(0)), 32'h011);
    check_subseq("overrun");

    // Randomized spaced traffic with glitches and framing errors
    for (int n = 0; n < 16; n++) begin
      rb   = 8'($urandom);
      kind = int'($urandom_range(0, 5));
      if (kind == 0) begin
        send_byte(rb, 1'b0, CPB);
        drive(1'b1, CPB);
      end else if (kind == 1) begin
        drive(1'b0, int'($urandom_range(2, HALF - 4)));
        drive(1'b1, CPB);
      end else begin
        send_good(rb, CPB);
      end
      drive(1'b1, int'($urandom_range(0, 2)) * CPB);
    end
    drive(1'b1, 15 * CPB);
    check_exact("random");

    // Random burst with shortened stop bits: receiver outruns transmitter
    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom);
      send_good(rb, (3 * CPB) / 4);
    end
    drive(1'b1, 30 * CPB);
    check_subseq("burst");

    // Reset in the middle of a received frame
    n0 = n_fall;
    drive(1'b0, 3 * CPB);
    rst_i = 1'b1;
    drive(1'b1, 2);
    rst_i = 1'b0;
    drive(1'b1, 14 * CPB);
    chk("rx_reset_no_tx", 32'(n_fall - n0), 32'd0);

    // Reset in the middle of an echo
    n0 = n_fall;
    send_byte(8'h5A, 1'b1, CPB);
    k = 0;
    while (n_fall == n0 && k < 2 * CPB) begin
      @(negedge clk_i);
      k++;
    end
    chk("echo_started_before_reset", 32'(n_fall - n0), 32'd1);
    repeat (3 * CPB) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("tx_high_after_reset_edge", 32'(uart_tx_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1'b1, 12 * CPB);
    chk("no_tx_after_reset", 32'(n_fall - n0), 32'd1);
    chk("aborted_frame_discarded", 32'(got_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_reg.md
Name: uart_reg

Overview:
- UART loopback register block: receives 8N1 frames on uart_rx_i, latches each good byte into an 8-bit data register, and retransmits it unchanged on uart_tx_o.
- Sits directly behind the board UART pins.
- Runs on the system clock; clock generation (PLL) and configuration-done gating live at top level, outside this block.

Parameters:
- CLK_FREQ, 10_000_000, clk_i frequency in Hz
- BAUD, 9600, line rate in bit/s
- CLKS_PER_BIT, CLK_FREQ/BAUD (=1041), derived localparam; bit period in clocks

Ports:
- clk_i  in  1  system clock, 10 MHz; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- uart_rx_i  in  1  asynchronous serial input, idle high
- uart_tx_o  out  1  serial output, idle high, registered

Behaviour:
- Reset:
  - uart_tx_o=1, both FSMs IDLE, data register=0x00, pending flag=0, rx synchronizer=11.
  - Reset asserted mid-frame aborts rx/tx; uart_tx_o is high at the clock edge after rst_i is sampled.
- Input sync: uart_rx_i passes through 2 flip-flops before any use.
- Frame format: 8N1, LSB first, no parity; one bit = CLKS_PER_BIT clocks; counter width ceil(log2(CLKS_PER_BIT)).
- RX FSM, states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: synced rx low -> START, counter cleared.
  - START: after CLKS_PER_BIT/2 clocks, sample. Low -> DATA. High (glitch) -> IDLE, nothing stored.
  - DATA: sample every CLKS_PER_BIT clocks (bit centre), shift into bit index 0..7. After bit 7 -> STOP.
  - STOP: sample after CLKS_PER_BIT clocks. High: load byte into data register, set pending, -> IDLE. Low (framing error): discard, -> WAIT_IDLE.
  - WAIT_IDLE: stay until synced rx high, then -> IDLE.
- Data register / pending:
  - Single entry. A new good byte overwrites the register even if the previous byte is not yet sent (latest wins).
  - If a store and a TX load happen on the same edge, the store wins and pending stays set.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE with pending=1: copy data register into shift register, clear pending, drive 0 -> START.
  - START: after CLKS_PER_BIT clocks -> DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT clocks -> STOP.
  - STOP: drive 1 for CLKS_PER_BIT clocks -> IDLE.
  - Minimum one stop bit between consecutive frames.
- Latency: tx start bit (falling edge on uart_tx_o) begins ≤3 clocks after the RX stop-bit sample, i.e. about half a bit after the RX stop bit starts.
- Baud error from integer division (1041 vs 1041.67) is 0.06%. This is acceptable; no fractional accumulator.
- No ready/valid handshake to other logic; the block is self-contained.

Decomposition:
- Shared package uart_pkg:
  - rx state enum, tx state enum
  - constants DATA_BITS=8 and STOP_BITS=1
  - function computing CLKS_PER_BIT
- One natural sub-module, uart_rx: synchronizer plus RX FSM, outputs byte and a 1-cycle valid pulse.
- TX FSM, data register and pending flag stay in uart_reg.

Test Plan:
- Reset: hold rst_i 2 cycles with uart_rx_i high -> uart_tx_o=1 throughout, no falling edge for 2 bit periods after release.
- Echo sweep: send 0x00..0x1F at 9600 baud, 3 bit periods idle between frames -> each byte returned on uart_tx_o. Sample at 1.5 bits after the falling edge, then every bit period; values match 0x00..0x1F in order.
- Pattern bytes: 0xA5, 0x5A, 0xFF, 0x80 -> identical bytes echoed; stop bit high; start bit ≤3 clocks + half bit after rx stop-bit start.
- Start glitch: rx low for 300 clocks, then high -> no transmission within 12 bit periods; a following 0x3C is echoed correctly.
- Framing error: frame 0x77 with stop bit 0, then line high -> no echo. The next frame 0x12 is echoed as 0x12.
- Overrun and reset:
  - Send 0x11, 0x22, 0x33 back-to-back with 1 stop bit, no idle -> 0x11 echoed, then the latest pending byte (0x33) echoed, no corruption.
  - Assert rst_i mid-echo -> uart_tx_o high next cycle, nothing further sent.
